// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_stage_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

  typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} lsu_state_e;

  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned MAX_ADDR  = MEM_BYTES - 8;

endpackage

// File: rtl/lsu_extend.sv
// Size lane logic: sign/zero extension of a load, or merging store bytes into an old doubleword.
module lsu_extend
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  size_e             size,
  input  logic              sgn,
  input  logic              merge,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0] mask;
  logic              sbit;

  always_comb begin
    mask = '1;
    sbit = 1'b0;
    unique case (size)
      SZ_B: begin
        mask = {{(DATA_W-8){1'b0}}, 8'hFF};
        sbit = din[7];
      end
      SZ_H: begin
        mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
        sbit = din[15];
      end
      SZ_W: begin
        mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
        sbit = din[31];
      end
      SZ_D: begin
        mask = '1;
        sbit = 1'b0;
      end
    endcase

    if (merge) begin
      res = (din & ~mask) | (wdata & mask);
    end else if (sgn && sbit) begin
      res = (din & mask) | ~mask;
    end else begin
      res = din & mask;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: 1-cycle loads, direct dword stores, 2-cycle read-modify-write
// for sub-dword stores against a memory that only writes whole 8-byte groups.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned REG_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [REG_W-1:0]  req_rd,
  output logic              stall,
  output logic [ADDR_W-1:0] dm_adr,
  output logic [DATA_W-1:0] dm_datain,
  output logic              dm_w,
  output logic              dm_r,
  input  logic [DATA_W-1:0] dm_dataout,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(MEM_BYTES - 8);

  lsu_state_e        state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] merge_q;
  logic [ADDR_W-1:0] addr_q;
  logic              capture;
  logic              illegal;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merge_res;
  size_e             size;

  assign size    = size_e'(req_size);
  assign illegal = req_valid & ((req_addr > MaxAddr) | (req_load == req_store));

  lsu_extend #(.DATA_W(DATA_W)) u_load_ext (
    .size  (size),
    .sgn   (req_signed),
    .merge (1'b0),
    .din   (dm_dataout),
    .wdata ('0),
    .res   (load_ext)
  );

  lsu_extend #(.DATA_W(DATA_W)) u_merge (
    .size  (size),
    .sgn   (1'b0),
    .merge (1'b1),
    .din   (dm_dataout),
    .wdata (req_wdata),
    .res   (merge_res)
  );

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    dm_w       = 1'b0;
    dm_r       = 1'b0;
    dm_adr     = req_addr;
    dm_datain  = req_wdata;
    wb_valid_d = 1'b0;
    fault_d    = 1'b0;
    capture    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (illegal) begin
          fault_d = 1'b1;
        end else if (req_valid && req_load) begin
          dm_r       = 1'b1;
          wb_valid_d = 1'b1;
        end else if (req_valid && size == SZ_D) begin
          dm_w = 1'b1;
        end else if (req_valid) begin
          dm_r    = 1'b1;
          stall   = 1'b1;
          capture = 1'b1;
          state_d = RMW_WR;
        end
      end
      RMW_WR: begin
        dm_w      = 1'b1;
        dm_adr    = addr_q;
        dm_datain = merge_q;
        state_d   = IDLE;
      end
    endcase

    // Memory controls must go quiet immediately, not at the next edge.
    if (reset) begin
      stall = 1'b0;
      dm_w  = 1'b0;
      dm_r  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      fault_q    <= 1'b0;
      merge_q    <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      fault_q    <= fault_d;
      if (wb_valid_d) begin
        wb_data_q <= load_ext;
        wb_rd_q   <= req_rd;
      end
      if (capture) begin
        merge_q <= merge_res;
        addr_q  <= req_addr;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a 256-byte memory model preloaded mem[i]=i.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load, req_store, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, dm_w, dm_r, wb_valid, fault;
  logic [63:0] dm_adr, dm_datain, dm_dataout, wb_data;
  logic [4:0]  wb_rd;

  logic [7:0]  mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .stall      (stall),
    .dm_adr     (dm_adr),
    .dm_datain  (dm_datain),
    .dm_w       (dm_w),
    .dm_r       (dm_r),
    .dm_dataout (dm_dataout),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .fault      (fault)
  );

  // Little-endian 8-byte window, combinational read, whole-group write.
  always_comb begin
    dm_dataout = '0;
    for (int i = 0; i < 8; i++) begin
      if (dm_adr + 64'(i) < 64'd256) dm_dataout[8*i +: 8] = mem[8'(dm_adr + 64'(i))];
    end
  end

  always @(posedge clk) begin
    if (dm_w && dm_adr <= 64'd248) begin
      for (int i = 0; i < 8; i++) mem[8'(dm_adr + 64'(i))] <= dm_datain[8*i +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                     input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    reset = 1'b1;
    idle();
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;

    // Reset: even with a valid store presented, controls stay low.
    req(1'b0, 1'b1, 2'd0, 1'b0, 64'h20, 64'hAB, 5'd0);
    #1;
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_dm_w", 64'(dm_w), 64'd0);
    check_eq("rst_dm_r", 64'(dm_r), 64'd0);
    tick();
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_wb_data", wb_data, 64'd0);
    check_eq("rst_fault", 64'(fault), 64'd0);
    idle();
    reset = 1'b0;
    tick();

    // 1. dword load
    req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 5'd3);
    #1;
    check_eq("t1_dm_r", 64'(dm_r), 64'd1);
    check_eq("t1_stall", 64'(stall), 64'd0);
    check_eq("t1_dm_adr", dm_adr, 64'h10);
    tick();
    check_eq("t1_wb_valid", 64'(wb_valid), 64'd1);
    check_eq("t1_wb_data", wb_data, 64'h1716151413121110);
    check_eq("t1_wb_rd", 64'(wb_rd), 64'd3);
    idle();
    tick();
    check_eq("t1_wb_drop", 64'(wb_valid), 64'd0);
    check_eq("t1_wb_hold", wb_data, 64'h1716151413121110);

    // 2. byte/half/word loads at 0x80
    req(1'b1, 1'b0, 2'd0, 1'b1, 64'h80, 64'h0, 5'd5);
    tick();
    check_eq("t2_lb", wb_data, 64'hFFFFFFFFFFFFFF80);
    check_eq("t2_lb_rd", 64'(wb_rd), 64'd5);
    req(1'b1, 1'b0, 2'd0, 1'b0, 64'h80, 64'h0, 5'd6);
    tick();
    check_eq("t2_lbu", wb_data, 64'h0000000000000080);
    req(1'b1, 1'b0, 2'd1, 1'b1, 64'h80, 64'h0, 5'd7);
    tick();
    check_eq("t2_lh", wb_data, 64'hFFFFFFFFFFFF8180);
    req(1'b1, 1'b0, 2'd2, 1'b0, 64'h80, 64'h0, 5'd8);
    tick();
    check_eq("t2_lwu", wb_data, 64'h0000000083828180);
    req(1'b1, 1'b0, 2'd3, 1'b1, 64'h80, 64'h0, 5'd9);
    tick();
    check_eq("t2_ld_sgn_ignored", wb_data, 64'h8786858483828180);

    // 3. byte store 0xAB at 0x20 via read-modify-write
    req(1'b0, 1'b1, 2'd0, 1'b0, 64'h20, 64'hFFFFFFFFFFFFFFAB, 5'd0);
    #1;
    check_eq("t3_c1_stall", 64'(stall), 64'd1);
    check_eq("t3_c1_dm_r", 64'(dm_r), 64'd1);
    check_eq("t3_c1_dm_w", 64'(dm_w), 64'd0);
    tick();
    req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 5'd1);  // must be ignored in RMW_WR
    #1;
    check_eq("t3_c2_dm_w", 64'(dm_w), 64'd1);
    check_eq("t3_c2_dm_r", 64'(dm_r), 64'd0);
    check_eq("t3_c2_stall", 64'(stall), 64'd0);
    check_eq("t3_c2_adr", dm_adr, 64'h20);
    check_eq("t3_c2_datain", dm_datain, 64'h27262524232221AB);
    tick();
    check_eq("t3_ignored_req", 64'(wb_valid), 64'd0);
    req(1'b1, 1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 5'd2);
    tick();
    check_eq("t3_readback", wb_data, 64'h27262524232221AB);

    // 4. dword store, then load next cycle
    req(1'b0, 1'b1, 2'd3, 1'b0, 64'h40, 64'h1122334455667788, 5'd0);
    #1;
    check_eq("t4_dm_w", 64'(dm_w), 64'd1);
    check_eq("t4_stall", 64'(stall), 64'd0);
    check_eq("t4_datain", dm_datain, 64'h1122334455667788);
    tick();
    check_eq("t4_wb_valid", 64'(wb_valid), 64'd0);
    req(1'b1, 1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 5'd4);
    tick();
    check_eq("t4_readback", wb_data, 64'h1122334455667788);

    // 5. faults, plus the highest legal address
    req(1'b1, 1'b0, 2'd3, 1'b0, 64'hF9, 64'h0, 5'd10);
    #1;
    check_eq("t5_oob_dm_r", 64'(dm_r), 64'd0);
    check_eq("t5_oob_dm_w", 64'(dm_w), 64'd0);
    tick();
    check_eq("t5_oob_fault", 64'(fault), 64'd1);
    check_eq("t5_oob_wb", 64'(wb_valid), 64'd0);
    req(1'b1, 1'b1, 2'd3, 1'b0, 64'h10, 64'h0, 5'd11);
    #1;
    check_eq("t5_both_dm_r", 64'(dm_r), 64'd0);
    check_eq("t5_both_dm_w", 64'(dm_w), 64'd0);
    tick();
    check_eq("t5_both_fault", 64'(fault), 64'd1);
    check_eq("t5_both_wb", 64'(wb_valid), 64'd0);
    req(1'b1, 1'b0, 2'd3, 1'b0, 64'hF8, 64'h0, 5'd12);
    tick();
    check_eq("t5_edge_fault", 64'(fault), 64'd0);
    check_eq("t5_edge_data", wb_data, 64'hFFFEFDFCFBFAF9F8);
    idle();
    tick();

    // 6. half store aborted by reset during RMW_WR
    req(1'b0, 1'b1, 2'd1, 1'b0, 64'h30, 64'hBEEF, 5'd0);
    tick();
    idle();
    #1;
    check_eq("t6_rmw_dm_w", 64'(dm_w), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_dm_w", 64'(dm_w), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("t6_post_dm_w", 64'(dm_w), 64'd0);
    req(1'b1, 1'b0, 2'd3, 1'b0, 64'h30, 64'h0, 5'd13);
    tick();
    check_eq("t6_readback", wb_data, 64'h3736353433323130);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM pipeline stage, placed directly upstream of the 64-bit byte-addressed data memory.
- Consumes EX/MEM requests and drives the memory's adr/datain/w/r.
- Produces size-selected, sign/zero-extended load results for MEM/WB.
- The data memory only writes whole 8-byte groups, so this block implements sub-doubleword stores as a read-modify-write, stalling the pipeline for one cycle.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_BYTES, 256, data memory size in bytes.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all registers on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX/MEM presents a memory op.
- req_load  in  1  op is a load.
- req_store  in  1  op is a store.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data; low bytes used.
- req_rd  in  REG_W  load destination register.
- stall  out  1  hold EX/MEM and earlier stages this cycle.
- dm_adr  out  ADDR_W  to data memory adr.
- dm_datain  out  DATA_W  to data memory datain.
- dm_w  out  1  to data memory w.
- dm_r  out  1  to data memory r.
- dm_dataout  in  DATA_W  from data memory; combinational read.
- wb_valid  out  1  load result valid, one-cycle pulse.
- wb_data  out  DATA_W  extended load result.
- wb_rd  out  REG_W  destination for wb_data.
- fault  out  1  one-cycle pulse: access rejected.

Behaviour:
- Reset: state=IDLE; wb_valid, wb_data, wb_rd, fault, and the merge/address registers all 0. stall, dm_w and dm_r go to 0 combinationally while reset is high.
- Fault: the request is illegal when req_valid & (addr > MEM_BYTES-8, or req_load==req_store). Then the access is suppressed (dm_w=dm_r=0), fault=1 the next cycle and wb_valid=0.
- IDLE, load:
  - dm_r=1, dm_adr=req_addr.
  - Next edge registers the extended dm_dataout into wb_data, with wb_rd=req_rd and wb_valid=1. Latency is 1 cycle; stall=0.
- Extension:
  - Select the low 8/16/32/64 bits.
  - When req_signed, replicate bit 7/15/31; otherwise zero-fill.
  - req_signed is ignored for dword.
- IDLE, dword store: dm_w=1, dm_datain=req_wdata, dm_adr=req_addr. Memory writes at the edge; no stall; wb_valid=0.
- IDLE, sub-dword store (size<3), cycle 1:
  - dm_r=1 and stall=1 (combinational).
  - Edge captures merge = {dm_dataout upper bytes, req_wdata low 1/2/4 bytes} and the address; go to RMW_WR.
- RMW_WR, cycle 2:
  - dm_w=1, dm_adr=captured address, dm_datain=merge, stall=0.
  - The req_* inputs are ignored in this state; the held request is not re-accepted.
  - Return to IDLE.
- Store-then-load: a load issued the cycle after a write completes sees the new data, because the write commits at the edge and the read is combinational.
- req_valid=0 in IDLE: dm_w=dm_r=0, dm_adr=req_addr (don't care), no pulses.
- Reset asserted in RMW_WR: write abandoned and memory unchanged; back to IDLE.
- wb_data and wb_rd hold their last values when wb_valid=0.

Decomposition:
- Package mem_stage_pkg:
  - size_e (SZ_B, SZ_H, SZ_W, SZ_D).
  - lsu_state_e (IDLE, RMW_WR).
  - Constants MEM_BYTES and MAX_ADDR=MEM_BYTES-8.
- Sub-module lsu_extend: combinational size select, sign/zero extension, and store-merge lane logic. It is instantiated twice, once for the load path and once for the merge path.
- The FSM and registers stay in mem_stage_lsu.

Test Plan (memory preloaded MEMO[i]=i):
1. Dword load, addr 0x10, rd=3 -> next cycle wb_valid=1, wb_data=0x1716151413121110, wb_rd=3; stall=0 throughout.
2. Byte loads at 0x80 -> signed gives wb_data=0xFFFFFFFFFFFFFF80; unsigned gives 0x0000000000000080.
3. Byte store 0xAB at 0x20:
   - Cycle 1: stall=1, dm_r=1.
   - Cycle 2: dm_w=1, dm_datain=0x27262524232221AB.
   - Following dword load at 0x20 returns 0x27262524232221AB.
4. Dword store 0x1122334455667788 at 0x40 -> dm_w=1 the same cycle, no stall; load at 0x40 next cycle returns 0x1122334455667788.
5. Load at 0xF9, and a request with req_load=req_store=1 -> dm_w=dm_r=0 and a fault pulse 1 cycle later; wb_valid stays 0.
6. Half store 0xBEEF at 0x30 with reset pulsed during RMW_WR -> dm_w drops immediately; a later dword load at 0x30 returns the original 0x3736353433323130.
